// File: rtl/serial_adder8_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder8_if
// Description : Operand/result valid-ready bundle for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder8_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder8.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder8
// Description : Bit-serial two's-complement adder, one full-adder cell, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder8 #(
    parameter int WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    serial_adder8_if.slave  bus
);
    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_out_valid;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_s;
    logic               w_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_shift;

    assign w_s     = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last  = (r_cnt == c_CNT_W'(WIDTH - 1));
    // Partial sum collects bits 0..WIDTH-2; the final bit completes it at capture.
    assign w_shift = {w_s, r_acc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_acc   <= w_shift[WIDTH-1:1];
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    // r_carry here is the carry into the MSB cell.
                    if (w_last) begin
                        r_sum  <= w_shift;
                        r_cout <= w_c;
                        r_ovf  <= r_carry ^ w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder8.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder8
// Description : Directed and random self-checking bench for serial_adder8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder8;
    localparam int c_WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n_acc;
    int   n_res;

    serial_adder8_if #(.WIDTH(c_WIDTH)) bus ();

    serial_adder8 #(.WIDTH(c_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction; all driving and sampling happens on falling edges.
    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] e_sum, input logic e_cout, input logic e_ovf,
                       input int stall);
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        n_acc++;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'd8);
        for (int i = 0; i < stall; i++) begin
            chk("stall_hold", 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        chk("sum", 32'(bus.sum), 32'(e_sum));
        chk("cout", 32'(bus.cout), 32'(e_cout));
        chk("ovf", 32'(bus.ovf), 32'(e_ovf));
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_res++;
        chk("in_ready_after", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb, es;
        logic       rc, eo;
        logic [8:0] full;

        n_vec = 0; n_err = 0; n_acc = 0; n_res = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic add and carry/overflow corners
        txn(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 0);
        txn(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        txn(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        txn(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        txn(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);

        // Backpressure and input isolation
        bus.a = 8'h0F; bus.b = 8'hF0; bus.cin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        n_acc++;
        for (int i = 0; i < 28; i++) begin
            bus.a        = bus.a ^ 8'h5A;
            bus.b        = bus.b + 8'd3;
            bus.in_valid = ~bus.in_valid;
            bus.cin      = ~bus.cin;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            if (i >= 8) begin
                chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_result", {23'd0, bus.cout, bus.ovf, bus.sum}, 32'h0FF);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_res++;
        bus.out_ready = 1'b0;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-operation
        bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) begin
            chk("mid_no_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        chk("mid_rst_result", {22'd0, bus.out_valid, bus.cout, bus.ovf, bus.sum}, 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("mid_stays_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
            @(negedge clk);
        end
        txn(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0, 0);

        // Random cross-check with output stalls
        for (int t = 0; t < 200; t++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            es   = full[7:0];
            eo   = (ra[7] == rb[7]) && (es[7] != ra[7]);
            txn(ra, rb, rc, es, full[8], eo, int'($urandom_range(0, 3)));
        end
        chk("txn_count", 32'(n_res), 32'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
